// File: rtl/pipe_shifter.sv
// Pipelined multi-mode barrel shifter: SHL, SHR logical, SHR arithmetic, ROTL.
// Stage 0 captures the operand. Stages 1..LOG2W each conditionally shift by a
// power of two. Oversize amounts are resolved at the final stage. The whole
// pipe freezes while the output is held by backpressure.
module pipe_shifter #(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] sh_amt,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 d_valid,
    input  logic                 d_ready
);

    localparam int unsigned LOG2W = $clog2(DATAWIDTH);
    localparam int unsigned NS    = LOG2W + 1;

    localparam logic [1:0] ModeShl = 2'b00;
    localparam logic [1:0] ModeShr = 2'b01;
    localparam logic [1:0] ModeSar = 2'b10;

    typedef logic [DATAWIDTH-1:0] word_t;

    // Data and valid exist for every stage. Sideband is only needed up to the
    // stage that feeds the final shift step.
    word_t            data_q [NS];
    word_t            data_d [NS];
    logic [NS-1:0]    valid_q, valid_d;
    logic [1:0]       mode_q [LOG2W];
    logic [1:0]       mode_d [LOG2W];
    logic [LOG2W-1:0] amt_q  [LOG2W];
    logic [LOG2W-1:0] amt_d  [LOG2W];
    logic [LOG2W-1:0] big_q, big_d;
    logic [LOG2W-1:0] sign_q, sign_d;
    logic             stall;
    word_t            step;

    // One shift step by a fixed power-of-two distance n (n <= DATAWIDTH/2).
    function automatic word_t shift_step(word_t x, logic [1:0] m, logic s, int unsigned n);
        word_t r;
        case (m)
            ModeShl: r = x << n;
            ModeShr: r = x >> n;
            ModeSar: r = (x >> n) | (s ? ~(~word_t'(0) >> n) : word_t'(0));
            default: r = (x << n) | (x >> (DATAWIDTH - n));
        endcase
        return r;
    endfunction

    // Backpressure freezes every stage; input readiness follows directly.
    always_comb begin
        stall    = valid_q[NS-1] && !d_ready;
        in_ready = !stall;
    end

    // Next-state for all stages: capture at stage 0, one shift step per later stage.
    always_comb begin
        data_d[0]  = a;
        valid_d    = '0;
        valid_d[0] = in_valid;
        mode_d[0]  = mode;
        amt_d[0]   = sh_amt[LOG2W-1:0];
        big_d      = '0;
        big_d[0]   = (sh_amt >> LOG2W) != '0;
        sign_d     = '0;
        sign_d[0]  = a[DATAWIDTH-1];
        step       = '0;

        for (int k = 1; k < LOG2W; k++) begin
            mode_d[k] = mode_q[k-1];
            amt_d[k]  = amt_q[k-1];
            big_d[k]  = big_q[k-1];
            sign_d[k] = sign_q[k-1];
        end

        for (int k = 1; k < NS; k++) begin
            step = data_q[k-1];
            if (amt_q[k-1][k-1]) begin
                step = shift_step(data_q[k-1], mode_q[k-1], sign_q[k-1], 1 << (k - 1));
            end
            // Oversize override; rotate keeps the mod-width result.
            if (k == LOG2W && big_q[k-1]) begin
                case (mode_q[k-1])
                    ModeShl, ModeShr: step = '0;
                    ModeSar:          step = {DATAWIDTH{sign_q[k-1]}};
                    default:          step = step;
                endcase
            end
            data_d[k]  = step;
            valid_d[k] = valid_q[k-1];
        end
    end

    // Pipeline registers: cleared on reset, all held together during a stall.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            data_q  <= '{default: '0};
            valid_q <= '0;
            mode_q  <= '{default: '0};
            amt_q   <= '{default: '0};
            big_q   <= '0;
            sign_q  <= '0;
        end else if (!stall) begin
            data_q  <= data_d;
            valid_q <= valid_d;
            mode_q  <= mode_d;
            amt_q   <= amt_d;
            big_q   <= big_d;
            sign_q  <= sign_d;
        end
    end

    assign d       = data_q[NS-1];
    assign d_valid = valid_q[NS-1];

endmodule
